td4x_core: RTL and testbench

- Parametrised successor to the 4-bit TD4E-class CPU core.
- Same accumulator ISA: A/B registers, OUT register, carry flag, ROM bank and RAM page registers.
- Generalised in data width, PC width, bank width and page width.
- Replaces single-cycle lockstep fetch/execute with a FETCH/EXEC/MEM state machine and valid/ack handshakes on the instruction and data buses, so slow ROM/RAM can insert wait states.

---
 rtl/td4x_core_if.sv | 28 ++
 rtl/td4x_core.sv | 164 ++++++++++++++++
 tb/tb_td4x_core.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/td4x_core_if.sv
// Instruction and data bus bundle for td4x_core.
// master = core side, slave = ROM/RAM side.
interface td4x_core_if #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4,
   parameter int PAGE_W = 4
) ();
   logic                     instr_req;
   logic [ADDR_W-1:0]        instr_addr;
   logic [DATA_W+3:0]        instr;
   logic                     instr_valid;
   logic                     data_req;
   logic                     data_we;
   logic [PAGE_W+DATA_W-1:0] data_addr;
   logic [DATA_W-1:0]        data_wdata;
   logic [DATA_W-1:0]        data_rdata;
   logic                     data_ack;

   modport master (
      output instr_req, instr_addr, data_req, data_we, data_addr, data_wdata,
      input  instr, instr_valid, data_rdata, data_ack
   );

   modport slave (
      input  instr_req, instr_addr, data_req, data_we, data_addr, data_wdata,
      output instr, instr_valid, data_rdata, data_ack
   );
endinterface

// File: rtl/td4x_core.sv
// Parametrised TD4-style accumulator CPU with FETCH/EXEC/MEM sequencing
// and valid/ack handshakes so slow ROM/RAM can stretch any access.
module td4x_core #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4,
   parameter int BANK_W = 4,
   parameter int PAGE_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   td4x_core_if.master       bus,
   input  logic [DATA_W-1:0] in_port,
   output logic [DATA_W-1:0] out_port,
   output logic [BANK_W-1:0] bank_out,
   output logic [PAGE_W-1:0] page_out,
   output logic              carry
);

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic [BANK_W-1:0] bank_q, bank_d;
   logic [PAGE_W-1:0] page_q, page_d;
   logic              carry_q, carry_d;
   logic [DATA_W+3:0] ir_q, ir_d;

   logic [3:0]        opcode;
   logic [DATA_W-1:0] imm;
   logic [DATA_W-1:0] src;
   logic [DATA_W:0]   sum;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] pc_imm;

   assign opcode = ir_q[DATA_W+3:DATA_W];
   assign imm    = ir_q[DATA_W-1:0];
   assign pc_inc = pc_q + ADDR_W'(1);
   assign pc_imm = ADDR_W'(imm);

   // Adder operand; MOV-immediate forms fall through to src=0.
   always_comb begin
      src = '0;
      case (opcode)
         4'b0000, 4'b0100: src = a_q;
         4'b0001, 4'b0101, 4'b1001: src = b_q;
         4'b0010, 4'b0110: src = in_port;
         default: src = '0;
      endcase
   end

   assign sum = {1'b0, src} + {1'b0, imm};

   // MEM-phase bus fields come straight from registers, so they hold until ack.
   assign bus.instr_addr = pc_q;
   assign bus.data_addr  = {page_q, imm};
   assign bus.data_we    = opcode[1];
   assign bus.data_wdata = a_q;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      a_d           = a_q;
      b_d           = b_q;
      out_d         = out_q;
      bank_d        = bank_q;
      page_d        = page_q;
      carry_d       = carry_q;
      ir_d          = ir_q;
      bus.instr_req = 1'b0;
      bus.data_req  = 1'b0;

      case (state_q)
         S_FETCH: begin
            bus.instr_req = 1'b1;
            if (bus.instr_valid) begin
               ir_d    = bus.instr;
               state_d = S_EXEC;
            end
         end

         S_EXEC: begin
            state_d = S_FETCH;
            pc_d    = pc_inc;
            carry_d = 1'b0;
            case (opcode)
               4'b0000, 4'b0001, 4'b0010: begin
                  a_d     = sum[DATA_W-1:0];
                  carry_d = sum[DATA_W];
               end
               4'b0011: a_d = imm;
               4'b0100, 4'b0101, 4'b0110: begin
                  b_d     = sum[DATA_W-1:0];
                  carry_d = sum[DATA_W];
               end
               4'b0111: b_d = imm;
               4'b1000, 4'b1010: begin
                  state_d = S_MEM;
                  pc_d    = pc_q;
                  carry_d = carry_q;
               end
               4'b1001: begin
                  out_d   = sum[DATA_W-1:0];
                  carry_d = sum[DATA_W];
               end
               4'b1011: out_d  = imm;
               4'b1100: bank_d = imm[BANK_W-1:0];
               4'b1101: page_d = imm[PAGE_W-1:0];
               4'b1110: if (!carry_q) pc_d = pc_imm;
               default: pc_d = pc_imm;
            endcase
         end

         S_MEM: begin
            bus.data_req = 1'b1;
            if (bus.data_ack) begin
               if (!opcode[1]) a_d = bus.data_rdata;
               carry_d = 1'b0;
               pc_d    = pc_inc;
               state_d = S_FETCH;
            end
         end

         default: state_d = S_FETCH;
      endcase

      if (reset) begin
         bus.instr_req = 1'b0;
         bus.data_req  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         out_q   <= '0;
         bank_q  <= '0;
         page_q  <= '0;
         carry_q <= 1'b0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         out_q   <= out_d;
         bank_q  <= bank_d;
         page_q  <= page_d;
         carry_q <= carry_d;
         ir_q    <= ir_d;
      end
   end

   assign out_port = out_q;
   assign bank_out = bank_q;
   assign page_out = page_q;
   assign carry    = carry_q;

endmodule

// File: tb/tb_td4x_core.sv
// Scoreboard bench for td4x_core: a 4-bit instance for ISA, wait-state and
// reset behaviour, and an 8-bit instance for PC wrap and 8-bit carry.
module tb_td4x_core;

   localparam int SEL_A4 = 0, SEL_B4 = 1, SEL_C4 = 2, SEL_OUT4 = 3;
   localparam int SEL_PC4 = 4, SEL_BANK4 = 5, SEL_PAGE4 = 6;
   localparam int SEL_A8 = 8, SEL_C8 = 10, SEL_PC8 = 12;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [3:0] in_port4 = 4'h0;
   logic [3:0] out_port4, bank_out4, page_out4;
   logic       carry4;
   logic [7:0] in_port8 = 8'h00;
   logic [7:0] out_port8;
   logic [3:0] bank_out8, page_out8;
   logic       carry8;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t0 = 0;
   bit hold_b_en = 1'b0;
   logic [3:0] hold_b = 4'h0;

   typedef struct {
      string       tag;
      int          sel;
      logic [15:0] exp;
   } sb_t;
   sb_t sb[$];

   td4x_core_if #(.DATA_W(4), .ADDR_W(4), .PAGE_W(4)) bus4 ();
   td4x_core_if #(.DATA_W(8), .ADDR_W(8), .PAGE_W(4)) bus8 ();

   td4x_core #(.DATA_W(4), .ADDR_W(4), .BANK_W(4), .PAGE_W(4)) dut4 (
      .clk(clk), .reset(reset), .bus(bus4), .in_port(in_port4),
      .out_port(out_port4), .bank_out(bank_out4), .page_out(page_out4),
      .carry(carry4)
   );

   td4x_core #(.DATA_W(8), .ADDR_W(8), .BANK_W(4), .PAGE_W(4)) dut8 (
      .clk(clk), .reset(reset), .bus(bus8), .in_port(in_port8),
      .out_port(out_port8), .bank_out(bank_out8), .page_out(page_out8),
      .carry(carry8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] obs(input int sel);
      case (sel)
         SEL_A4:    return 16'(dut4.a_q);
         SEL_B4:    return 16'(dut4.b_q);
         SEL_C4:    return 16'(carry4);
         SEL_OUT4:  return 16'(out_port4);
         SEL_PC4:   return 16'(bus4.instr_addr);
         SEL_BANK4: return 16'(bank_out4);
         SEL_PAGE4: return 16'(page_out4);
         SEL_A8:    return 16'(dut8.a_q);
         SEL_C8:    return 16'(carry8);
         SEL_PC8:   return 16'(bus8.instr_addr);
         default:   return 16'hDEAD;
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input logic [15:0] v);
      sb_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic drain();
      sb_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk(e.tag, obs(e.sel), e.exp);
      end
   endtask

   // Runs one instruction on dut4 from a FETCH negedge to the next FETCH negedge.
   task automatic run4(input logic [7:0] ins, input logic [3:0] exp_pc,
                       input int fwait, input int mwait, input logic [3:0] rdata,
                       input logic [7:0] exp_daddr, input logic [3:0] exp_wdata);
      bit is_mem;
      is_mem = ins[7] && !ins[6] && !ins[4];
      chk("fetch_req", 16'(bus4.instr_req), 16'd1);
      chk("fetch_addr", 16'(bus4.instr_addr), 16'(exp_pc));
      for (int w = 0; w < fwait; w++) begin
         bus4.instr_valid = 1'b0;
         bus4.instr = ins;
         @(posedge clk); @(negedge clk);
         chk("wait_req", 16'(bus4.instr_req), 16'd1);
         chk("wait_addr", 16'(bus4.instr_addr), 16'(exp_pc));
         if (hold_b_en) chk("wait_b_hold", 16'(dut4.b_q), 16'(hold_b));
      end
      bus4.instr = ins;
      bus4.instr_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      bus4.instr_valid = 1'b0;
      bus4.instr = 8'h5A;
      chk("exec_noreq", 16'(bus4.instr_req), 16'd0);
      if (is_mem) begin
         @(posedge clk); @(negedge clk);
         for (int w = 0; w <= mwait; w++) begin
            chk("mem_req", 16'(bus4.data_req), 16'd1);
            chk("mem_addr", 16'(bus4.data_addr), 16'(exp_daddr));
            chk("mem_we", 16'(bus4.data_we), 16'(ins[5]));
            if (ins[5]) chk("mem_wdata", 16'(bus4.data_wdata), 16'(exp_wdata));
            bus4.data_rdata = rdata;
            bus4.data_ack = (w == mwait);
            @(posedge clk); @(negedge clk);
         end
         bus4.data_ack = 1'b0;
      end else begin
         @(posedge clk); @(negedge clk);
      end
      $display("tb: dut4 instr %h at pc %h done, cycle %0d", ins, exp_pc, cyc);
      drain();
   endtask

   task automatic run8(input logic [11:0] ins, input logic [7:0] exp_pc);
      chk("fetch8_addr", 16'(bus8.instr_addr), 16'(exp_pc));
      bus8.instr = ins;
      bus8.instr_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      bus8.instr_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      $display("tb: dut8 instr %h at pc %h done, cycle %0d", ins, exp_pc, cyc);
      drain();
   endtask

   initial begin
      bus4.instr = '0; bus4.instr_valid = 1'b0; bus4.data_rdata = '0; bus4.data_ack = 1'b0;
      bus8.instr = '0; bus8.instr_valid = 1'b0; bus8.data_rdata = '0; bus8.data_ack = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_instr_req", 16'(bus4.instr_req), 16'd0);
      chk("rst_data_req", 16'(bus4.data_req), 16'd0);
      reset = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("rst_pc", 16'(bus4.instr_addr), 16'd0);
      chk("rst_a", 16'(dut4.a_q), 16'd0);
      chk("rst_b", 16'(dut4.b_q), 16'd0);
      chk("rst_out", 16'(out_port4), 16'd0);
      chk("rst_carry", 16'(carry4), 16'd0);
      chk("rst_bank", 16'(bank_out4), 16'd0);
      chk("rst_page", 16'(page_out4), 16'd0);
      t0 = cyc;

      // MOV A,3; ADD A,14; JNC 0 (not taken); OUT 5
      push("mov_a3", SEL_A4, 16'd3); push("mov_a3_pc", SEL_PC4, 16'd1);
      run4(8'h33, 4'd0, 0, 0, 4'h0, 8'h00, 4'h0);
      push("add14_a", SEL_A4, 16'd1); push("add14_c", SEL_C4, 16'd1);
      push("add14_pc", SEL_PC4, 16'd2);
      run4(8'h0E, 4'd1, 0, 0, 4'h0, 8'h00, 4'h0);
      push("jnc_nt_pc", SEL_PC4, 16'd3); push("jnc_c", SEL_C4, 16'd0);
      run4(8'hE0, 4'd2, 0, 0, 4'h0, 8'h00, 4'h0);
      push("out5", SEL_OUT4, 16'd5); push("out5_pc", SEL_PC4, 16'd4);
      run4(8'hB5, 4'd3, 0, 0, 4'h0, 8'h00, 4'h0);
      chk("out5_cycle", 16'(cyc - t0), 16'd8);

      // JMP 0; MOV A,15; ADD A,1 twice (carry not sticky)
      push("jmp0_pc", SEL_PC4, 16'd0);
      run4(8'hF0, 4'd4, 0, 0, 4'h0, 8'h00, 4'h0);
      push("mov_a15", SEL_A4, 16'd15);
      run4(8'h3F, 4'd0, 0, 0, 4'h0, 8'h00, 4'h0);
      push("wrap_a", SEL_A4, 16'd0); push("wrap_c", SEL_C4, 16'd1);
      run4(8'h01, 4'd1, 0, 0, 4'h0, 8'h00, 4'h0);
      push("add1_a", SEL_A4, 16'd1); push("add1_c", SEL_C4, 16'd0);
      push("add1_pc", SEL_PC4, 16'd3);
      run4(8'h01, 4'd2, 0, 0, 4'h0, 8'h00, 4'h0);

      // Fetch wait states on MOV B,9
      push("jmp0b_pc", SEL_PC4, 16'd0);
      run4(8'hF0, 4'd3, 0, 0, 4'h0, 8'h00, 4'h0);
      hold_b_en = 1'b1; hold_b = 4'h0;
      push("mov_b9", SEL_B4, 16'd9); push("mov_b9_pc", SEL_PC4, 16'd1);
      run4(8'h79, 4'd0, 3, 0, 4'h0, 8'h00, 4'h0);
      hold_b_en = 1'b0;

      // PAGE 2; MOV A,7; ST with 2 ack waits; LD returns 0xA
      push("page2", SEL_PAGE4, 16'd2);
      run4(8'hD2, 4'd1, 0, 0, 4'h0, 8'h00, 4'h0);
      push("mov_a7", SEL_A4, 16'd7);
      run4(8'h37, 4'd2, 0, 0, 4'h0, 8'h00, 4'h0);
      push("st_a", SEL_A4, 16'd7); push("st_c", SEL_C4, 16'd0);
      push("st_pc", SEL_PC4, 16'd4);
      run4(8'hA5, 4'd3, 0, 2, 4'h3, 8'h25, 4'h7);
      push("ld_a", SEL_A4, 16'hA); push("ld_pc", SEL_PC4, 16'd5);
      run4(8'h86, 4'd4, 0, 0, 4'hA, 8'h26, 4'h0);
      push("bank3", SEL_BANK4, 16'd3);
      run4(8'hC3, 4'd5, 0, 0, 4'h0, 8'h00, 4'h0);
      push("out_b1", SEL_OUT4, 16'hA); push("out_b1_c", SEL_C4, 16'd0);
      run4(8'h91, 4'd6, 0, 0, 4'h0, 8'h00, 4'h0);

      // Reset while an LD waits in MEM; a late ack must not write A
      chk("ldp_addr", 16'(bus4.instr_addr), 16'd7);
      bus4.instr = 8'h81; bus4.instr_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      bus4.instr_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("ldp_mem_req", 16'(bus4.data_req), 16'd1);
      reset = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("ldp_rst_dreq", 16'(bus4.data_req), 16'd0);
      chk("ldp_rst_ireq", 16'(bus4.instr_req), 16'd0);
      chk("ldp_rst_pc", 16'(bus4.instr_addr), 16'd0);
      chk("ldp_rst_a", 16'(dut4.a_q), 16'd0);
      reset = 1'b0;
      bus4.data_rdata = 4'hF; bus4.data_ack = 1'b1;
      @(posedge clk); @(negedge clk);
      bus4.data_ack = 1'b0;
      chk("late_ack_a", 16'(dut4.a_q), 16'd0);
      chk("late_ack_fetch", 16'(bus4.instr_req), 16'd1);
      chk("late_ack_dreq", 16'(bus4.data_req), 16'd0);
      chk("late_ack_pc", 16'(bus4.instr_addr), 16'd0);

      // 8-bit: JMP 0xFF, then two ADD A,0x80 across the PC wrap
      push("jmpff_pc", SEL_PC8, 16'hFF);
      run8(12'hFFF, 8'h00);
      push("add80_a", SEL_A8, 16'h80); push("add80_c", SEL_C8, 16'd0);
      push("pc_wrap", SEL_PC8, 16'h00);
      run8(12'h080, 8'hFF);
      push("add80b_a", SEL_A8, 16'h00); push("add80b_c", SEL_C8, 16'd1);
      push("add80b_pc", SEL_PC8, 16'h01);
      run8(12'h080, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
